// File: rtl/dcache_if_pkg.sv
// Shared types and constants for the HLS ap_memory data-cache requester.
package dcache_if_pkg;

  localparam int DCACHE_LATENCY = 3;
  localparam int DCACHE_MASK_W  = 4;
  localparam int DCACHE_ADDR_W  = 8;
  localparam int DCACHE_DATA_W  = 32;

  typedef struct packed {
    logic                     we;
    logic [DCACHE_ADDR_W-1:0] addr;
    logic [DCACHE_MASK_W-1:0] mask;
    logic [DCACHE_DATA_W-1:0] wdata;
  } dcache_cmd_t;

endpackage

// File: rtl/dcache_rsp_fifo.sv
// First-word fall-through response FIFO; rsp_data reads as zero while empty.
module dcache_rsp_fifo #(
  parameter int DBITS = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DBITS-1:0] push_data,
  input  logic             rsp_ready,
  output logic             rsp_valid,
  output logic [DBITS-1:0] rsp_data,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DBITS-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             wr_en;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid & rsp_ready;
  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign wr_en     = push & (~full | pop);
  assign rsp_data  = rsp_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= ptr_next(wr_ptr);
      if (pop)   rd_ptr <= ptr_next(rd_ptr);
      if (wr_en & ~pop)      count <= count + CW'(1);
      else if (pop & ~wr_en) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/dcache_initiator.sv
// Drives commands onto a clock-enabled ram_1p cache port, tracks in-flight reads
// against the expected return latency and returns read data in order.
module dcache_initiator
  import dcache_if_pkg::*;
#(
  parameter int ABITS     = 8,
  parameter int DBITS     = 32,
  parameter int LATENCY   = DCACHE_LATENCY,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     freeze,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_we,
  input  logic [ABITS-1:0]         cmd_addr,
  input  logic [DCACHE_MASK_W-1:0] cmd_mask,
  input  logic [DBITS-1:0]         cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DBITS-1:0]         rsp_data,
  output logic                     hls_ap_ce,
  input  logic                     ready,
  output logic [ABITS-1:0]         address0,
  output logic                     ce0,
  output logic                     we0,
  output logic [DCACHE_MASK_W-1:0] we_mask,
  output logic [DBITS-1:0]         d0,
  input  logic [DBITS-1:0]         q0,
  input  logic                     q0_vld,
  output logic                     busy,
  output logic                     err_latency,
  output logic                     err_timeout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  dcache_cmd_t        cmd;
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        credits;
  logic [LATENCY-1:0] exp_q;
  logic [LATENCY-1:0] exp_nxt;
  logic [WW-1:0]      wd_cnt;
  logic               rd_issue;
  logic               capture;

  assign hls_ap_ce = ~rst & ~freeze;
  assign credits   = {1'b0, inflight} + {1'b0, fifo_count};
  assign cmd_ready = hls_ap_ce & ready & (credits < (CW + 1)'(RSP_DEPTH));

  always_comb begin
    cmd       = '0;
    cmd.we    = cmd_we;
    cmd.addr  = cmd_addr;
    cmd.mask  = cmd_we ? cmd_mask : '0;
    cmd.wdata = cmd_wdata;
  end

  assign ce0      = cmd_valid & cmd_ready;
  assign address0 = cmd.addr;
  assign we0      = cmd.we;
  assign we_mask  = cmd.mask;
  assign d0       = cmd.wdata;

  assign rd_issue = ce0 & ~cmd_we;
  // A return with nothing outstanding is flagged but never enters the FIFO,
  // so it cannot consume a credit that was never granted.
  assign capture  = q0_vld & hls_ap_ce & (inflight != '0);

  always_comb begin
    exp_nxt    = exp_q << 1;
    exp_nxt[0] = rd_issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q       <= '0;
      inflight    <= '0;
      wd_cnt      <= '0;
      err_latency <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      if (hls_ap_ce) begin
        exp_q <= exp_nxt;
        if (exp_q[LATENCY-1] != q0_vld) err_latency <= 1'b1;
      end
      if (rd_issue & ~capture)      inflight <= inflight + CW'(1);
      else if (capture & ~rd_issue) inflight <= inflight - CW'(1);
      // Watchdog measures time since the last return while reads remain open.
      if (capture || inflight == '0) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WW'(TIMEOUT)) begin
        wd_cnt <= wd_cnt + WW'(1);
        if (wd_cnt == WW'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
  end

  dcache_rsp_fifo #(
    .DBITS (DBITS),
    .DEPTH (RSP_DEPTH),
    .CW    (CW)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (q0),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .count     (fifo_count)
  );

  assign busy = (inflight != '0) | rsp_valid;

endmodule

// File: tb/tb_dcache_initiator.sv
// Directed bench for dcache_initiator with a latency-3 clock-enabled cache model.
module tb_dcache_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_addr;
  logic [3:0]  cmd_mask;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        hls_ap_ce;
  logic        ready;
  logic [7:0]  address0;
  logic        ce0;
  logic        we0;
  logic [3:0]  we_mask;
  logic [31:0] d0;
  logic [31:0] q0;
  logic        q0_vld;
  logic        busy;
  logic        err_latency;
  logic        err_timeout;

  logic [31:0] mem [64];
  logic [2:0]  s_vld;
  logic [31:0] s_data [3];
  logic        inj;
  logic        drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_initiator dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .hls_ap_ce(hls_ap_ce), .ready(ready), .address0(address0), .ce0(ce0),
    .we0(we0), .we_mask(we_mask), .d0(d0), .q0(q0), .q0_vld(q0_vld),
    .busy(busy), .err_latency(err_latency), .err_timeout(err_timeout)
  );

  // Cache model: byte-masked write at issue, three ce-qualified stages to q0_vld.
  always @(posedge clk) begin
    if (hls_ap_ce && ce0 && we0) begin
      for (int b = 0; b < 4; b++)
        if (we_mask[b]) mem[address0[7:2]][b*8 +: 8] <= d0[b*8 +: 8];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_vld <= 3'b000;
    end else if (hls_ap_ce) begin
      s_vld     <= {s_vld[1:0], ce0 & ~we0};
      s_data[0] <= mem[address0[7:2]];
      s_data[1] <= s_data[0];
      s_data[2] <= s_data[1];
    end
  end

  assign q0_vld = (s_vld[2] & ~drop) | inj;
  assign q0     = s_data[2];

  task automatic issue(input logic we, input logic [7:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, output logic ok);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_mask = mask; cmd_wdata = data;
    #1 ok = cmd_ready;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop_one();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
    total++; if (ce0 !== 1'b0) begin bad++; $display("FAIL reset_ce0: got %b want 0", ce0); end
    total++; if (hls_ap_ce !== 1'b0) begin bad++; $display("FAIL reset_ce: got %b want 0", hls_ap_ce); end
    total++; if ({rsp_valid, busy, err_latency, err_timeout} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, busy, err_latency, err_timeout});
    end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    cmd_valid = 1'b0;
  endtask

  task automatic test_write_read();
    logic ok; int cyc;
    issue(1'b1, 8'h10, 4'hF, 32'hDEADBEEF, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wr_handshake: got %b want 1", ok); end
    issue(1'b0, 8'h10, 4'hF, 32'h0, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rd_handshake: got %b want 1", ok); end
    wait_rsp(cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL rd_latency: got %0d edges want 3", cyc); end
    total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", rsp_data); end
    pop_one();
    total++; if ({busy, err_latency, err_timeout} !== 3'b000) begin
      bad++; $display("FAIL rd_flags: got %b want 000", {busy, err_latency, err_timeout});
    end
  endtask

  task automatic test_masked_write();
    logic ok; int cyc;
    issue(1'b1, 8'h20, 4'hF, 32'hAABBCCDD, ok);
    issue(1'b1, 8'h20, 4'b0101, 32'h11223344, ok);
    issue(1'b0, 8'h20, 4'hF, 32'h0, ok);
    wait_rsp(cyc);
    total++; if (rsp_data !== 32'hAA22CC44) begin bad++; $display("FAIL masked_data: got %h want aa22cc44", rsp_data); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [4];
    want[0] = 32'hDEADBEEF; want[1] = 32'hAA22CC44; want[2] = 32'hDEADBEEF; want[3] = 32'hAA22CC44;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = (i % 2 == 0) ? 8'h10 : 8'h20;
      #1;
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready); end
      @(negedge clk);
    end
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_credit_stall: got %b want 0", cmd_ready); end
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    total++; if ({rsp_valid, cmd_ready} !== 2'b10) begin
      bad++; $display("FAIL b2b_full: got %b want 10", {rsp_valid, cmd_ready});
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_data !== want[i]) begin bad++; $display("FAIL b2b_order_%0d: got %h want %h", i, rsp_data, want[i]); end
      pop_one();
      if (i == 0) begin
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_recover: got %b want 1", cmd_ready); end
      end
    end
    total++; if ({rsp_valid, busy} !== 2'b00) begin bad++; $display("FAIL b2b_drain: got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_freeze();
    logic ok; int cyc; logic ce_seen;
    issue(1'b0, 8'h10, 4'hF, 32'h0, ok);
    freeze = 1'b1;
    cyc = 0; ce_seen = 1'b1;
    while (!rsp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) ce_seen = hls_ap_ce;
      if (cyc == 5) freeze = 1'b0;
    end
    total++; if (ce_seen !== 1'b0) begin bad++; $display("FAIL frz_ce: got %b want 0", ce_seen); end
    total++; if (cyc != 8) begin bad++; $display("FAIL frz_latency: got %0d edges want 8", cyc); end
    total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL frz_data: got %h want deadbeef", rsp_data); end
    pop_one();
    repeat (3) @(negedge clk);
    total++; if ({rsp_valid, busy, err_latency} !== 3'b000) begin
      bad++; $display("FAIL frz_once: got %b want 000", {rsp_valid, busy, err_latency});
    end
  endtask

  task automatic test_errors();
    logic ok;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    total++; if ({err_latency, rsp_valid} !== 2'b10) begin
      bad++; $display("FAIL err_lat_set: got %b want 10", {err_latency, rsp_valid});
    end
    repeat (3) @(negedge clk);
    total++; if (err_latency !== 1'b1) begin bad++; $display("FAIL err_lat_sticky: got %b want 1", err_latency); end
    drop = 1'b1;
    issue(1'b0, 8'h10, 4'hF, 32'h0, ok);
    repeat (63) @(negedge clk);
    total++; if ({err_timeout, busy} !== 2'b01) begin
      bad++; $display("FAIL err_to_early: got %b want 01", {err_timeout, busy});
    end
    @(negedge clk);
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL err_to_set: got %b want 1", err_timeout); end
  endtask

  task automatic test_reset_midflight();
    logic ok; int cyc;
    rst = 1'b1;
    @(negedge clk);
    drop = 1'b0; rst = 1'b0;
    total++; if ({err_latency, err_timeout} !== 2'b00) begin
      bad++; $display("FAIL rst_clear_err: got %b want 00", {err_latency, err_timeout});
    end
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = (i == 1) ? 8'h20 : 8'h10;
      @(negedge clk);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    total++; if ({cmd_ready, ce0, hls_ap_ce, busy, rsp_valid, err_latency, err_timeout} !== 7'b0) begin
      bad++; $display("FAIL rst_mid_outputs: got %b want 0000000",
                      {cmd_ready, ce0, hls_ap_ce, busy, rsp_valid, err_latency, err_timeout});
    end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rst_mid_data: got %h want 0", rsp_data); end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 8'h20, 4'hF, 32'h0, ok);
    wait_rsp(cyc);
    total++; if (cyc != 3) begin bad++; $display("FAIL rst_post_latency: got %0d edges want 3", cyc); end
    total++; if (rsp_data !== 32'hAA22CC44) begin bad++; $display("FAIL rst_post_data: got %h want aa22cc44", rsp_data); end
    pop_one();
    total++; if ({err_latency, err_timeout, busy} !== 3'b000) begin
      bad++; $display("FAIL rst_post_flags: got %b want 000", {err_latency, err_timeout, busy});
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; freeze = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h0;
    cmd_mask = 4'h0; cmd_wdata = 32'h0; rsp_ready = 1'b0; ready = 1'b1;
    inj = 1'b0; drop = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_write_read();
    test_masked_write();
    test_back_to_back();
    test_freeze();
    test_errors();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
